// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// instruction field positions and default widths.
package instr_fetch_unit_pkg;

  localparam int unsigned PC_W_DEF    = 12;
  localparam int unsigned IW_DEF      = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Instruction field bit positions within the IR
  localparam int unsigned IT_MSB  = 15;
  localparam int unsigned IT_LSB  = 13;
  localparam int unsigned OPC_MSB = 12;
  localparam int unsigned OPC_LSB = 10;
  localparam int unsigned C_MSB   = 9;
  localparam int unsigned C_LSB   = 8;
  localparam int unsigned I_BIT   = 7;
  localparam int unsigned LD_BIT  = 6;
  localparam int unsigned LB_BIT  = 5;
  localparam int unsigned IMM_MSB = 4;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with next-PC select (increment or target).
module fetch_pc_reg #(
  parameter int unsigned PC_W     = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcwrite,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] pc_target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_next;

  // Increment wraps naturally at the register width
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pcsrc) pc_next = pc_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (pcwrite) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory request per fetch, captures the
// returned word into the IR, decodes its fields and holds the ALU flags.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned IW       = IW_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch,
  input  logic            pcwrite,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] pc_target,
  input  logic            loadf,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_v,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic            busy,
  output logic            ir_valid,
  output logic            fetch_err,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      it,
  output logic [2:0]      opc,
  output logic [1:0]      C,
  output logic            i,
  output logic            ld,
  output logic            lb,
  output logic [4:0]      imm,
  output logic            z,
  output logic            n,
  output logic            v
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [PC_W-1:0] fetch_addr;
  logic [IW-1:0]   ir;
  logic [CNT_W-1:0] wait_cnt;

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .pcwrite   (pcwrite),
    .pcsrc     (pcsrc),
    .pc_target (pc_target),
    .pc        (pc)
  );

  // Address comes straight from the captured register so PC updates never disturb it
  assign imem_addr = fetch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= PC_W'(RESET_PC);
      ir         <= '0;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      busy       <= 1'b0;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch) begin
            fetch_addr <= pc;
            wait_cnt   <= '0;
            imem_req   <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still wins over the timeout
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Flags update only on loadf, regardless of fetch activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z <= 1'b0;
      n <= 1'b0;
      v <= 1'b0;
    end else if (loadf) begin
      z <= alu_z;
      n <= alu_n;
      v <= alu_v;
    end
  end

  assign it  = ir[IT_MSB:IT_LSB];
  assign opc = ir[OPC_MSB:OPC_LSB];
  assign C   = ir[C_MSB:C_LSB];
  assign i   = ir[I_BIT];
  assign ld  = ir[LD_BIT];
  assign lb  = ir[LB_BIT];
  assign imm = ir[IMM_MSB:IMM_LSB];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 12: program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter IW, default 16: instruction width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15: maximum number of cycles to wait for imem_ack.
REQ-004 The block SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port fetch, input, 1 bit: controller request to start an instruction fetch.
REQ-008 The block SHALL have ports pcwrite, input, 1 bit, and pcsrc, input, 1 bit: PC update enable and next-PC select (0 = PC+1, 1 = pc_target).
REQ-009 The block SHALL have port pc_target, input, PC_W bits: branch/jump target from the datapath.
REQ-010 The block SHALL have port loadf, input, 1 bit, and ports alu_z, alu_n, alu_v, input, 1 bit each: flag-load enable and ALU flags.
REQ-011 The block SHALL have ports imem_req, output, 1 bit, and imem_addr, output, PC_W bits: instruction-memory request and address.
REQ-012 The block SHALL have ports imem_ack, input, 1 bit, and imem_rdata, input, IW bits: memory acknowledge and read data.
REQ-013 The block SHALL have ports busy, ir_valid and fetch_err, output, 1 bit each, and pc, output, PC_W bits.
REQ-014 The block SHALL have decoded outputs from the IR: it[2:0] = IR[15:13], opc[2:0] = IR[12:10], C[1:0] = IR[9:8], i = IR[7], ld = IR[6], lb = IR[5], imm[4:0] = IR[4:0].
REQ-015 The block SHALL have ports z, n and v, output, 1 bit each: registered flags.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-017 In IDLE, fetch=1 SHALL capture pc into the fetch-address register and move to REQ on the next edge.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the captured fetch address, held stable until ack or timeout.
REQ-019 In REQ, imem_ack=1 SHALL load imem_rdata into the IR and move to DONE; data SHALL be sampled only in a cycle where both imem_req and imem_ack are 1.
REQ-020 DONE SHALL last exactly one cycle with ir_valid=1 and then return to IDLE; the minimum latency from fetch to ir_valid is 2 cycles for a same-cycle ack.
REQ-021 A wait counter SHALL be cleared on entry to REQ and incremented each REQ cycle without ack; reaching TIMEOUT without ack SHALL pulse fetch_err for 1 cycle, return to IDLE and leave the IR unchanged.
REQ-022 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success, with no error.
REQ-023 busy SHALL be 1 in REQ and DONE; fetch while busy SHALL be ignored, not queued.
REQ-024 pcwrite=1 SHALL update pc in any state: pcsrc=0 gives pc+1 modulo 2^PC_W (all-ones wraps to 0), and pcsrc=1 gives pc_target.
REQ-025 A pcwrite during REQ SHALL NOT change imem_addr.
REQ-026 fetch and pcwrite in the same IDLE cycle SHALL fetch from the old pc while pc updates.
REQ-027 loadf=1 SHALL register alu_z, alu_n and alu_v into z, n and v; otherwise the flags SHALL hold, independent of the FSM state.
REQ-028 The decoded outputs SHALL be combinational slices of the IR and SHALL be stable whenever ir_valid=0.

Reset
REQ-029 Asserting rst SHALL force, without waiting for clk: FSM to IDLE, pc to RESET_PC, IR to 0, fetch address to RESET_PC, wait counter to 0, z, n and v to 0, and imem_req, busy, ir_valid and fetch_err to 0.
REQ-030 Reset asserted during REQ SHALL drop imem_req immediately, and an ack arriving while rst=1 SHALL be ignored.
REQ-031 The first edge after rst deasserts SHALL behave as IDLE.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), the instruction field bit positions and the default widths.
REQ-033 One sub-module, fetch_pc_reg, SHALL hold the PC register and next-PC mux; the FSM, IR and flags SHALL stay in the top module.

Verification
REQ-034 With rst=0, pc=0x000, a fetch pulse and a same-cycle ack with rdata=0xA5C3, the bench SHALL see imem_addr=0x000, ir_valid after 2 cycles, it=5, opc=1, C=1, i=1, ld=1, lb=0 and imem=0x03.
REQ-035 With ack delayed 4 cycles, the bench SHALL see imem_req held 4 cycles with a constant address, busy=1 throughout, and a second fetch in that window ignored.
REQ-036 With no ack, the bench SHALL see fetch_err pulse after 15 REQ cycles, the IR unchanged and the FSM back in IDLE; with ack on cycle 15 there SHALL be no error.
REQ-037 With pc=0xFFF, pcwrite=1 and pcsrc=0, the bench SHALL see pc=0x000; with pcsrc=1 and pc_target=0x3C0, pc=0x3C0 even while in REQ with imem_addr unchanged.
REQ-038 With loadf=1 and alu flags z=1, n=0, v=1, the bench SHALL see z=1, n=0, v=1, which then hold through 3 cycles of loadf=0 with the alu inputs toggling.
REQ-039 Asserting rst mid-REQ SHALL drop imem_req in the same cycle with pc=RESET_PC, and a fetch after release SHALL proceed normally.
